// File: rtl/acc_pkg.sv
// Shared definitions for the sequential accumulator slice.
//   state_t : controller phase encoding (IDLE, ACCUM, DONE), 2 bits.
//   DATA_W  : operand / sum width in bits.
package acc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : acc_pkg

// File: rtl/carry_sel_adder.sv
// 16-bit carry-select adder.
// The low half is a plain ripple adder. The high half is computed twice,
// once for each possible carry into it. The low half's carry-out then
// selects which high result to use.
// Ports:
//   a, b : DATA_W-bit addends
//   cin  : carry-in
//   sum  : DATA_W-bit sum (modulo 2^DATA_W)
//   cout : carry-out of the most significant bit
module carry_sel_adder
  import acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  localparam int LO_W = DATA_W / 2;
  localparam int HI_W = DATA_W - LO_W;

  logic [LO_W:0] lo;
  logic [HI_W:0] hi0;
  logic [HI_W:0] hi1;

  assign lo  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
  assign hi0 = {1'b0, a[DATA_W-1:LO_W]} + {1'b0, b[DATA_W-1:LO_W]};
  assign hi1 = {1'b0, a[DATA_W-1:LO_W]} + {1'b0, b[DATA_W-1:LO_W]} + (HI_W+1)'(1);

  // The low-half carry picks the precomputed high half.
  assign sum  = {(lo[LO_W] ? hi1[HI_W-1:0] : hi0[HI_W-1:0]), lo[LO_W-1:0]};
  assign cout = lo[LO_W] ? hi1[HI_W] : hi0[HI_W];

endmodule : carry_sel_adder

// File: rtl/seq_accumulator.sv
// Sequential accumulator around carry_sel_adder.
// A job begins with a start pulse that carries an operand count. The block
// then accepts that many operands over a valid/ready stream and adds one
// operand per cycle. It presents the 16-bit sum and a sticky overflow flag
// on a valid/ready result port.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   start, count        : job request and operand count (sampled in IDLE only)
//   in_valid/in_ready   : operand handshake, in_data is the operand
//   out_valid/out_ready : result handshake
//   out_sum, out_carry  : result sum (mod 2^16) and sticky adder carry-out
//   busy                : high while a job is in ACCUM or DONE
module seq_accumulator
  import acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic              busy
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              in_fire;

  carry_sel_adder u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The handshake depends on in_valid. It drives only state, never an output.
  assign in_fire = (state == ACCUM) && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that were present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state takes a default first, so no path through the case can
  // infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (count == '0) ? DONE : ACCUM;
      ACCUM:   if (in_fire && remaining == CNT_W'(1)) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The datapath registers hold their values in DONE. This keeps the result
  // stable under backpressure. A start pulse outside IDLE is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carry     <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      carry     <= 1'b0;
      remaining <= count;
    end else if (in_fire) begin
      acc       <= add_sum;
      carry     <= carry | add_cout;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_carry = carry;

endmodule : seq_accumulator

// File: tb/tb_seq_accumulator.sv
// Directed testbench for seq_accumulator. Expected values are hand-computed.
module tb_seq_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  count = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_accumulator #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock. Inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    count = n;
    cyc();
    start = 1'b0;
    count = 8'hAA;  // mid-job changes to count must have no effect
  endtask

  // Present one operand and wait (bounded) for it to be accepted.
  // in_valid is left high so that consecutive calls run back-to-back.
  task automatic feed(input logic [15:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 20) begin
      cyc();
      guard++;
    end
    if (!in_ready) check("feed_timeout", 32'(in_ready), 32'd1);
    cyc();
  endtask

  task automatic take_result(input string tag, input logic [15:0] s, input logic c);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      cyc();
      guard++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(s));
    check({tag, "_carry"}, 32'(out_carry), 32'(c));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'({out_valid, busy}), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc();
    check("rst_outs", 32'({in_ready, out_valid, busy, out_carry}), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("idle_outs", 32'({in_ready, out_valid, busy}), 32'd0);

    // Reset mid-job
    start_job(8'd4);
    check("accum_ready", 32'({in_ready, busy}), 32'b11);
    feed(16'h0001);
    feed(16'h0002);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("midrst_outs", 32'({in_ready, out_valid, busy}), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;
    cyc();
    start_job(8'd1);
    feed(16'h0005);
    in_valid = 1'b0;
    take_result("after_rst", 16'h0005, 1'b0);

    // Basic sum, back-to-back. The result must be valid immediately after the 3rd beat.
    start_job(8'd3);
    feed(16'h0001);
    feed(16'h0002);
    feed(16'h0003);
    in_valid = 1'b0;
    check("basic_latency", 32'(out_valid), 32'd1);
    take_result("basic", 16'h0006, 1'b0);

    // Overflow and wrap
    start_job(8'd2);
    feed(16'hFFFF);
    feed(16'h0002);
    in_valid = 1'b0;
    take_result("wrap", 16'h0001, 1'b1);
    // The carry flag must clear at the start of the next job.
    start_job(8'd2);
    feed(16'h0080);
    feed(16'h0080);
    in_valid = 1'b0;
    take_result("lo_carry", 16'h0100, 1'b0);

    // Stalls and backpressure
    start_job(8'd4);
    for (int i = 1; i <= 4; i++) begin
      feed(16'(i));
      in_valid = 1'b0;
      in_data  = 16'hDEAD;  // must be ignored while in_valid is low
      if (i < 4) cyc();
    end
    check("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_hold", 32'({out_valid, out_carry, out_sum}), 32'({1'b1, 1'b0, 16'h000A}));
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, busy}), 32'd0);

    // count == 0: DONE the cycle after start
    start_job(8'd0);
    check("zero_done", 32'({out_valid, busy, in_ready}), 32'b110);
    take_result("zero", 16'h0000, 1'b0);

    // count == 255
    start_job(8'd255);
    for (int i = 0; i < 255; i++) feed(16'h0101);
    in_valid = 1'b0;
    take_result("max_cnt", 16'hFFFF, 1'b0);

    // Start pulse in ACCUM is dropped
    start_job(8'd2);
    feed(16'h0007);
    in_valid = 1'b0;
    start = 1'b1;
    count = 8'd9;
    cyc();
    start = 1'b0;
    feed(16'h0008);
    in_valid = 1'b0;
    check("drop_len", 32'(out_valid), 32'd1);
    take_result("drop", 16'h000F, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    check("drop_no_job", 32'({busy, in_ready, out_valid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_accumulator
